// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: ALU operation codes, opcodes, operand selects
// and the control bundle passed from the decoder to the ID/EX register.
package riscv_pkg;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_SLL   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SRL   = 5'd8;
  localparam logic [4:0] ALU_SRA   = 5'd9;
  localparam logic [4:0] ALU_ADDR  = 5'd10;
  localparam logic [4:0] ALU_BEQ   = 5'd11;
  localparam logic [4:0] ALU_BNE   = 5'd12;
  localparam logic [4:0] ALU_BLT   = 5'd13;
  localparam logic [4:0] ALU_BGE   = 5'd14;
  localparam logic [4:0] ALU_BLTU  = 5'd15;
  localparam logic [4:0] ALU_BGEU  = 5'd16;
  localparam logic [4:0] ALU_PASSB = 5'd17;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  typedef struct packed {
    logic [4:0]  alu_opt;
    logic [1:0]  a_sel;
    logic [1:0]  b_sel;
    logic [31:0] imm;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        shamt_mask;
    logic        illegal;
    logic        rs1_used;
    logic        rs2_used;
  } id_ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// Combinational RV32I decoder: instruction word to ALU code, operand selects,
// control flags, source-usage bits and the sign-extended immediate.
module id_decoder
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output id_ctrl_t    ctrl
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    ctrl         = '0;
    ctrl.alu_opt = ALU_ADD;
    ctrl.a_sel   = A_RS1;
    ctrl.b_sel   = B_RS2;
    case (opcode)
      LUI: begin
        ctrl.alu_opt = ALU_PASSB;
        ctrl.a_sel   = A_ZERO;
        ctrl.b_sel   = B_IMM;
        ctrl.imm     = imm_u;
        ctrl.reg_we  = 1'b1;
      end
      AUIPC: begin
        ctrl.a_sel  = A_PC;
        ctrl.b_sel  = B_IMM;
        ctrl.imm    = imm_u;
        ctrl.reg_we = 1'b1;
      end
      JAL: begin
        ctrl.a_sel  = A_PC;
        ctrl.b_sel  = B_FOUR;
        ctrl.imm    = imm_j;
        ctrl.reg_we = 1'b1;
        ctrl.is_jal = 1'b1;
      end
      JALR: begin
        // ALU produces the link value; the target rs1+imm is formed in EX
        ctrl.a_sel    = A_PC;
        ctrl.b_sel    = B_FOUR;
        ctrl.imm      = imm_i;
        ctrl.reg_we   = 1'b1;
        ctrl.is_jalr  = 1'b1;
        ctrl.rs1_used = 1'b1;
        ctrl.illegal  = (funct3 != 3'd0);
      end
      BRANCH: begin
        ctrl.imm       = imm_b;
        ctrl.is_branch = 1'b1;
        ctrl.rs1_used  = 1'b1;
        ctrl.rs2_used  = 1'b1;
        case (funct3)
          3'd0:    ctrl.alu_opt = ALU_BEQ;
          3'd1:    ctrl.alu_opt = ALU_BNE;
          3'd4:    ctrl.alu_opt = ALU_BLT;
          3'd5:    ctrl.alu_opt = ALU_BGE;
          3'd6:    ctrl.alu_opt = ALU_BLTU;
          3'd7:    ctrl.alu_opt = ALU_BGEU;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      LOAD: begin
        ctrl.alu_opt  = ALU_ADDR;
        ctrl.b_sel    = B_IMM;
        ctrl.imm      = imm_i;
        ctrl.mem_re   = 1'b1;
        ctrl.reg_we   = 1'b1;
        ctrl.rs1_used = 1'b1;
        ctrl.illegal  = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      STORE: begin
        ctrl.alu_opt  = ALU_ADDR;
        ctrl.b_sel    = B_IMM;
        ctrl.imm      = imm_s;
        ctrl.mem_we   = 1'b1;
        ctrl.rs1_used = 1'b1;
        ctrl.rs2_used = 1'b1;
        ctrl.illegal  = (funct3 > 3'd2);
      end
      OP_IMM: begin
        ctrl.b_sel    = B_IMM;
        ctrl.imm      = imm_i;
        ctrl.reg_we   = 1'b1;
        ctrl.rs1_used = 1'b1;
        case (funct3)
          3'd0: ctrl.alu_opt = ALU_ADD;
          3'd1: begin
            ctrl.alu_opt = ALU_SLL;
            ctrl.illegal = (funct7 != 7'd0);
          end
          3'd2: ctrl.alu_opt = ALU_SLT;
          3'd3: ctrl.alu_opt = ALU_SLTU;
          3'd4: ctrl.alu_opt = ALU_XOR;
          3'd5: begin
            // SRAI keeps imm[10] set but imm[11] clear, so the ALU needs no mask
            if (funct7 == 7'b0000000)      ctrl.alu_opt = ALU_SRL;
            else if (funct7 == 7'b0100000) ctrl.alu_opt = ALU_SRA;
            else                           ctrl.illegal = 1'b1;
          end
          3'd6: ctrl.alu_opt = ALU_OR;
          default: ctrl.alu_opt = ALU_AND;
        endcase
      end
      OP: begin
        ctrl.reg_we   = 1'b1;
        ctrl.rs1_used = 1'b1;
        ctrl.rs2_used = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'd0: ctrl.alu_opt = ALU_ADD;
            3'd1: ctrl.alu_opt = ALU_SLL;
            3'd2: ctrl.alu_opt = ALU_SLT;
            3'd3: ctrl.alu_opt = ALU_SLTU;
            3'd4: ctrl.alu_opt = ALU_XOR;
            3'd5: ctrl.alu_opt = ALU_SRL;
            3'd6: ctrl.alu_opt = ALU_OR;
            default: ctrl.alu_opt = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
          ctrl.alu_opt = ALU_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
          ctrl.alu_opt    = ALU_SRA;
          ctrl.shamt_mask = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase

    if (ctrl.illegal) begin
      ctrl.reg_we     = 1'b0;
      ctrl.mem_re     = 1'b0;
      ctrl.mem_we     = 1'b0;
      ctrl.is_branch  = 1'b0;
      ctrl.is_jal     = 1'b0;
      ctrl.is_jalr    = 1'b0;
      ctrl.shamt_mask = 1'b0;
    end
    if (instr[11:7] == 5'd0) ctrl.reg_we = 1'b0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register with flush, stall and load-use
// bubble insertion.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            id_ready,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic            ex_valid,
  output logic [4:0]      ex_alu_opt,
  output logic [1:0]      ex_a_sel,
  output logic [1:0]      ex_b_sel,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_we,
  output logic            ex_mem_re,
  output logic            ex_mem_we,
  output logic [2:0]      ex_funct3,
  output logic            ex_is_branch,
  output logic            ex_is_jal,
  output logic            ex_is_jalr,
  output logic            ex_shamt_mask,
  output logic            ex_illegal
);

  id_ctrl_t dec;
  logic     hazard;
  logic     bubble;

  id_decoder u_id_decoder (
    .instr (if_instr),
    .ctrl  (dec)
  );

  assign id_rs1 = if_instr[19:15];
  assign id_rs2 = if_instr[24:20];

  assign hazard = ex_valid && ex_mem_re && (ex_rd != 5'd0) &&
                  ((dec.rs1_used && (ex_rd == id_rs1)) ||
                   (dec.rs2_used && (ex_rd == id_rs2)));
  assign id_ready = !hazard && !ex_stall;

  // flush beats stall; otherwise a stall freezes the register
  assign bubble = flush || (!ex_stall && (hazard || !if_valid));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_opt    <= ALU_ADD;
      ex_a_sel      <= A_RS1;
      ex_b_sel      <= B_RS2;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_pc         <= RESET_PC;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_we     <= 1'b0;
      ex_mem_re     <= 1'b0;
      ex_mem_we     <= 1'b0;
      ex_funct3     <= '0;
      ex_is_branch  <= 1'b0;
      ex_is_jal     <= 1'b0;
      ex_is_jalr    <= 1'b0;
      ex_shamt_mask <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (bubble) begin
      ex_valid      <= 1'b0;
      ex_reg_we     <= 1'b0;
      ex_mem_re     <= 1'b0;
      ex_mem_we     <= 1'b0;
      ex_is_branch  <= 1'b0;
      ex_is_jal     <= 1'b0;
      ex_is_jalr    <= 1'b0;
      ex_shamt_mask <= 1'b0;
      ex_illegal    <= 1'b0;
    end else if (!ex_stall) begin
      ex_valid      <= 1'b1;
      ex_alu_opt    <= dec.alu_opt;
      ex_a_sel      <= dec.a_sel;
      ex_b_sel      <= dec.b_sel;
      ex_rs1_data   <= rf_rs1_data;
      ex_rs2_data   <= rf_rs2_data;
      ex_imm        <= dec.imm;
      ex_pc         <= if_pc;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= if_instr[11:7];
      ex_reg_we     <= dec.reg_we;
      ex_mem_re     <= dec.mem_re;
      ex_mem_we     <= dec.mem_we;
      ex_funct3     <= if_instr[14:12];
      ex_is_branch  <= dec.is_branch;
      ex_is_jal     <= dec.is_jal;
      ex_is_jalr    <= dec.is_jalr;
      ex_shamt_mask <= dec.shamt_mask;
      ex_illegal    <= dec.illegal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus a randomized stream checked
// against a mnemonic-level decode model and a per-edge register model.
module tb_id_ex_stage;

  localparam logic [31:0] RST_PC = 32'h8000_0040;

  typedef struct packed {
    logic        valid;
    logic [4:0]  opt;
    logic [1:0]  asel;
    logic [1:0]  bsel;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        re;
    logic        mwe;
    logic [2:0]  f3;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        mask;
    logic        ill;
  } ex_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = '0;
  logic [31:0] if_pc = '0;
  logic [31:0] rf_rs1_data = '0;
  logic [31:0] rf_rs2_data = '0;
  logic        ex_stall = 1'b0;
  logic        flush = 1'b0;
  logic        id_ready;
  logic [4:0]  id_rs1, id_rs2;
  logic        ex_valid;
  logic [4:0]  ex_alu_opt;
  logic [1:0]  ex_a_sel, ex_b_sel;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_we, ex_mem_re, ex_mem_we;
  logic [2:0]  ex_funct3;
  logic        ex_is_branch, ex_is_jal, ex_is_jalr, ex_shamt_mask, ex_illegal;

  int errors = 0;
  int checks = 0;

  int r_tab  [8] = '{0, 5, 6, 7, 4, 8, 3, 2};
  int br_tab [8] = '{11, 12, 0, 0, 13, 14, 15, 16};
  int ld_f3  [5] = '{0, 1, 2, 4, 5};
  int bf3    [6] = '{0, 1, 4, 5, 6, 7};

  ex_t        obs;
  logic [8:0] obs_flags;

  assign obs = {ex_valid, ex_alu_opt, ex_a_sel, ex_b_sel, ex_imm, ex_pc, ex_rs1_data,
                ex_rs2_data, ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_mem_re, ex_mem_we,
                ex_funct3, ex_is_branch, ex_is_jal, ex_is_jalr, ex_shamt_mask, ex_illegal};
  assign obs_flags = {ex_valid, ex_reg_we, ex_mem_re, ex_mem_we, ex_is_branch,
                      ex_is_jal, ex_is_jalr, ex_shamt_mask, ex_illegal};

  id_ex_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .ex_stall(ex_stall),
    .flush(flush), .id_ready(id_ready), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_alu_opt(ex_alu_opt), .ex_a_sel(ex_a_sel),
    .ex_b_sel(ex_b_sel), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .ex_funct3(ex_funct3), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_shamt_mask(ex_shamt_mask), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  // Reference decode for legal instructions, by mnemonic class
  function automatic ex_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                     input logic [31:0] d1, input logic [31:0] d2);
    ex_t e;
    logic [2:0] f3;
    f3 = i[14:12];
    e = '0;
    e.valid = 1'b1; e.pc = pc; e.d1 = d1; e.d2 = d2;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.f3 = f3;
    case (i[6:0])
      7'h37: begin e.opt = 5'd17; e.asel = 2'd2; e.bsel = 2'd1; e.imm = i & 32'hFFFF_F000; e.we = 1; end
      7'h17: begin e.asel = 2'd1; e.bsel = 2'd1; e.imm = i & 32'hFFFF_F000; e.we = 1; end
      7'h6F: begin
        e.asel = 2'd1; e.bsel = 2'd2; e.we = 1; e.jal = 1;
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      7'h67: begin e.asel = 2'd1; e.bsel = 2'd2; e.we = 1; e.jalr = 1; e.imm = 32'($signed(i[31:20])); end
      7'h63: begin
        e.opt = 5'(br_tab[f3]); e.br = 1;
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h03: begin e.opt = 5'd10; e.bsel = 2'd1; e.re = 1; e.we = 1; e.imm = 32'($signed(i[31:20])); end
      7'h23: begin e.opt = 5'd10; e.bsel = 2'd1; e.mwe = 1; e.imm = 32'($signed({i[31:25], i[11:7]})); end
      7'h13: begin
        e.bsel = 2'd1; e.we = 1; e.imm = 32'($signed(i[31:20]));
        e.opt = (f3 == 3'd5 && i[30]) ? 5'd9 : 5'(r_tab[f3]);
      end
      default: begin
        e.we = 1;
        e.opt = i[30] ? ((f3 == 3'd0) ? 5'd1 : 5'd9) : 5'(r_tab[f3]);
        e.mask = i[30] && (f3 == 3'd5);
      end
    endcase
    if (e.rd == 5'd0) e.we = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] i;
    logic [2:0]  f3;
    int cls;
    i = $urandom;
    cls = $urandom_range(0, 10);
    f3 = 3'($urandom_range(0, 7));
    i[11:7] = 5'($urandom_range(0, 3));
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    case (cls)
      0, 1: begin
        i[6:0] = 7'h33;
        i[31:25] = ((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      2: begin
        i[6:0] = 7'h13;
        if (f3 == 3'd1) i[31:25] = 7'h00;
        if (f3 == 3'd5) i[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      end
      3, 4: begin i[6:0] = 7'h03; f3 = 3'(ld_f3[$urandom_range(0, 4)]); end
      5: begin i[6:0] = 7'h23; f3 = 3'($urandom_range(0, 2)); end
      6: begin i[6:0] = 7'h63; f3 = 3'(bf3[$urandom_range(0, 5)]); end
      7: i[6:0] = 7'h6F;
      8: begin i[6:0] = 7'h67; f3 = 3'd0; end
      9: i[6:0] = 7'h37;
      default: i[6:0] = 7'h17;
    endcase
    if (i[6:0] != 7'h6F && i[6:0] != 7'h37 && i[6:0] != 7'h17) i[14:12] = f3;
    return i;
  endfunction

  task automatic drive(input logic [31:0] instr, input logic v, input logic st, input logic fl);
    @(negedge clk);
    if_instr = instr; if_valid = v; ex_stall = st; flush = fl;
    if_pc = $urandom & 32'hFFFF_FFFC; rf_rs1_data = $urandom; rf_rs2_data = $urandom;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    ex_t e;
    e = '0;
    e.pc = RST_PC;
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, e);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    logic [31:0] pc;
    drive(32'h002081B3, 1, 0, 0);
    pc = if_pc;
    tick();
    checks++;
    if ({ex_valid, ex_alu_opt, ex_a_sel, ex_b_sel, ex_rd, ex_reg_we, ex_pc} !==
        {1'b1, 5'd0, 2'd0, 2'd0, 5'd3, 1'b1, pc}) begin
      errors++;
      $display("FAIL add: got v=%b opt=%0d a=%0d b=%0d rd=%0d we=%b pc=%h, expected 1/0/0/0/3/1/%h",
               ex_valid, ex_alu_opt, ex_a_sel, ex_b_sel, ex_rd, ex_reg_we, ex_pc, pc);
    end
    drive(32'h40335293, 1, 0, 0);
    tick();
    checks++;
    if ({ex_alu_opt, ex_b_sel, ex_imm, ex_shamt_mask} !== {5'd9, 2'd1, 32'h0000_0403, 1'b0}) begin
      errors++;
      $display("FAIL srai: got opt=%0d b=%0d imm=%h mask=%b, expected 9/1/00000403/0",
               ex_alu_opt, ex_b_sel, ex_imm, ex_shamt_mask);
    end
    drive(32'h407352B3, 1, 0, 0);
    tick();
    checks++;
    if ({ex_alu_opt, ex_b_sel, ex_shamt_mask} !== {5'd9, 2'd0, 1'b1}) begin
      errors++;
      $display("FAIL sra: got opt=%0d b=%0d mask=%b, expected 9/0/1", ex_alu_opt, ex_b_sel, ex_shamt_mask);
    end
  endtask

  task automatic test_load_use();
    drive(32'h00012083, 1, 0, 0);
    tick();
    checks++;
    if ({ex_valid, ex_mem_re, ex_rd} !== {1'b1, 1'b1, 5'd1}) begin
      errors++;
      $display("FAIL lw_capture: got v=%b re=%b rd=%0d, expected 1/1/1", ex_valid, ex_mem_re, ex_rd);
    end
    drive(32'h002081B3, 1, 0, 0);
    #1;
    checks++;
    if (id_ready !== 1'b0) begin
      errors++;
      $display("FAIL hazard_ready: got %b expected 0", id_ready);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL hazard_bubble: ex_valid got %b expected 0", ex_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL hazard_release: id_ready got %b expected 1", id_ready);
    end
    tick();
    checks++;
    if ({ex_valid, ex_rd, ex_alu_opt, ex_reg_we} !== {1'b1, 5'd3, 5'd0, 1'b1}) begin
      errors++;
      $display("FAIL hazard_add: got v=%b rd=%0d opt=%0d we=%b, expected 1/3/0/1",
               ex_valid, ex_rd, ex_alu_opt, ex_reg_we);
    end
  endtask

  task automatic test_branch_stall_flush();
    drive(32'h00208463, 1, 0, 0);
    tick();
    checks++;
    if ({ex_valid, ex_alu_opt, ex_is_branch, ex_imm, ex_reg_we} !== {1'b1, 5'd11, 1'b1, 32'd8, 1'b0}) begin
      errors++;
      $display("FAIL beq: got v=%b opt=%0d br=%b imm=%h we=%b, expected 1/11/1/8/0",
               ex_valid, ex_alu_opt, ex_is_branch, ex_imm, ex_reg_we);
    end
    drive(32'h002081B3, 1, 1, 0);
    tick();
    checks++;
    if ({ex_valid, ex_alu_opt, ex_is_branch, ex_rd} !== {1'b1, 5'd11, 1'b1, 5'd8}) begin
      errors++;
      $display("FAIL stall_hold: got v=%b opt=%0d br=%b rd=%0d, expected 1/11/1/8",
               ex_valid, ex_alu_opt, ex_is_branch, ex_rd);
    end
    drive(32'h002081B3, 1, 1, 1);
    tick();
    checks++;
    if (obs_flags !== 9'b0) begin
      errors++;
      $display("FAIL flush_over_stall: flags got %b expected 000000000", obs_flags);
    end
    drive(32'h0, 0, 0, 0);
    tick();
  endtask

  task automatic test_illegal();
    drive(32'hFFFF_FFFF, 1, 0, 0);
    tick();
    checks++;
    if ({ex_valid, ex_illegal, ex_reg_we, ex_mem_re, ex_mem_we} !== 5'b11000) begin
      errors++;
      $display("FAIL illegal: got v=%b ill=%b we=%b re=%b mwe=%b, expected 1/1/0/0/0",
               ex_valid, ex_illegal, ex_reg_we, ex_mem_re, ex_mem_we);
    end
    drive(32'h0010_0013, 1, 0, 0);
    tick();
    checks++;
    if ({ex_valid, ex_illegal, ex_reg_we, ex_imm} !== {3'b100, 32'd1}) begin
      errors++;
      $display("FAIL addi_x0: got v=%b ill=%b we=%b imm=%h, expected 1/0/0/1",
               ex_valid, ex_illegal, ex_reg_we, ex_imm);
    end
  endtask

  task automatic test_async_reset();
    drive(32'h002081B3, 1, 0, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_valid, ex_pc} !== {1'b0, RST_PC}) begin
      errors++;
      $display("FAIL async_reset: got v=%b pc=%h, expected 0/%h", ex_valid, ex_pc, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    if_instr = 32'h002081B3; if_valid = 1'b1;
    #1;
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ex_valid got %b expected 0", ex_valid);
    end
    tick();
    checks++;
    if ({ex_valid, ex_rd} !== {1'b1, 5'd3}) begin
      errors++;
      $display("FAIL post_reset_first: got v=%b rd=%0d, expected 1/3", ex_valid, ex_rd);
    end
  endtask

  task automatic test_random();
    ex_t m;
    logic haz, u1, u2, rdy;
    logic [6:0] op;
    @(negedge clk);
    rst_n = 1'b0;
    if_valid = 1'b0; ex_stall = 1'b0; flush = 1'b0;
    #2;
    rst_n = 1'b1;
    m = '0;
    m.pc = RST_PC;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if_instr = gen_instr();
      if_valid = ($urandom_range(0, 9) < 8);
      ex_stall = ($urandom_range(0, 9) < 2);
      flush = ($urandom_range(0, 9) == 0);
      if_pc = $urandom; rf_rs1_data = $urandom; rf_rs2_data = $urandom;
      #1;
      op = if_instr[6:0];
      u1 = (op == 7'h33) || (op == 7'h13) || (op == 7'h03) || (op == 7'h23) ||
           (op == 7'h63) || (op == 7'h67);
      u2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
      haz = m.valid && m.re && (m.rd != 5'd0) &&
            ((u1 && m.rd == if_instr[19:15]) || (u2 && m.rd == if_instr[24:20]));
      rdy = !haz && !ex_stall;
      checks++;
      if ({id_ready, id_rs1, id_rs2} !== {rdy, if_instr[19:15], if_instr[24:20]}) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got rdy=%b rs=%0d/%0d expected rdy=%b rs=%0d/%0d",
                 n, id_ready, id_rs1, id_rs2, rdy, if_instr[19:15], if_instr[24:20]);
      end
      if (flush || (!ex_stall && (haz || !if_valid))) begin
        m.valid = 0; m.we = 0; m.re = 0; m.mwe = 0; m.br = 0;
        m.jal = 0; m.jalr = 0; m.mask = 0; m.ill = 0;
      end else if (!ex_stall) begin
        m = ref_decode(if_instr, if_pc, rf_rs1_data, rf_rs2_data);
      end
      tick();
      checks++;
      if (m.valid) begin
        if (obs !== m) begin
          errors++;
          $display("FAIL rand_capture[%0d]: got %h expected %h", n, obs, m);
        end
      end else if (obs_flags !== 9'b0) begin
        errors++;
        $display("FAIL rand_bubble[%0d]: flags got %b expected 000000000", n, obs_flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_use();
    test_branch_stall_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
